serial_comparator: RTL and testbench



---
 rtl/cmp_pkg.sv | 29 ++
 rtl/serial_cmp_cell.sv | 26 ++
 rtl/serial_comparator.sv | 130 +++++++++++++
 tb/tb_serial_comparator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM state
// encoding, the 2-bit relation code carried between beats, and a helper
// that expands a relation into the one-hot {h, e, l} result.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Relation of the operand prefixes seen so far (A versus B).
  localparam logic [1:0] REL_EQ = 2'b00;
  localparam logic [1:0] REL_GT = 2'b01;
  localparam logic [1:0] REL_LT = 2'b10;

  // Expand a relation code into {h, e, l}. The unused code 2'b11 never
  // occurs; it is folded onto "equal" so the result stays one-hot.
  function automatic logic [2:0] rel_to_hel(input logic [1:0] rel);
    logic [2:0] hel;
    case (rel)
      REL_GT:  hel = 3'b100;
      REL_LT:  hel = 3'b001;
      default: hel = 3'b010;
    endcase
    return hel;
  endfunction

endpackage

// File: rtl/serial_cmp_cell.sv
// One step of the MSB-first comparison: given the relation decided by
// the more significant bits and the current bit pair, produce the
// relation including this bit. Purely combinational so it can be chained
// for a parallel or hybrid comparator later.
module serial_cmp_cell
  import cmp_pkg::*;
(
  input  logic [1:0] rel,
  input  logic       a,
  input  logic       b,
  output logic [1:0] rel_next,
  output logic       decided
);

  // A more significant difference always wins, so only an EQ prefix can
  // be changed by the current bit.
  always_comb begin
    rel_next = rel;
    if ((rel == REL_EQ) && (a != b)) begin
      rel_next = a ? REL_GT : REL_LT;
    end
  end

  assign decided = (rel_next != REL_EQ);

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first, with a
// valid/ready beat handshake. The result (h/e/l) is registered and held
// until the next comparison finishes. Build option:
//   SERIAL_CMP_EARLY_EXIT_EN - finish on the first differing bit instead
//   of always consuming WIDTH beats; results are identical, only latency
//   and bit_cnt change.
module serial_comparator
  import cmp_pkg::*;
#(
  parameter  int WIDTH = 8,            // operand width, 2..32
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  output logic             busy,
  output logic             done,
  output logic             h,
  output logic             e,
  output logic             l,
  output logic [CNT_W-1:0] bit_cnt
);

  state_t           state_reg;
  state_t           state_next;
  logic [1:0]       rel_reg;
  logic [1:0]       rel_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       hel_reg;
  logic             load_result;

  logic [1:0]       rel_step;
  logic             step_decided;
  logic             accept;
  logic             last_beat;
  logic             finish;

  serial_cmp_cell u_cell (
    .rel      (rel_reg),
    .a        (a),
    .b        (b),
    .rel_next (rel_step),
    .decided  (step_decided)
  );

  assign in_ready  = (state_reg == SHIFT);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt_reg == CNT_W'(WIDTH - 1));

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  // rel_reg is still EQ whenever we are in SHIFT, so "decided" here means
  // this very beat carried the first difference.
  assign finish = accept && (last_beat || step_decided);
`else
  // step_decided is only needed for early exit; the full-length build
  // always runs to the last beat.
  logic unused_decided;
  assign unused_decided = step_decided;
  assign finish = accept && last_beat;
`endif

  // Next-state, beat counter and relation update.
  always_comb begin
    state_next  = state_reg;
    rel_next    = rel_reg;
    cnt_next    = cnt_reg;
    load_result = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          cnt_next   = '0;
          rel_next   = REL_EQ;
        end
      end
      SHIFT: begin
        if (accept) begin
          cnt_next = cnt_reg + CNT_W'(1);
          rel_next = rel_step;
          if (finish) begin
            state_next  = DONE;
            load_result = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state: FSM, relation and beat count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      rel_reg   <= REL_EQ;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rel_reg   <= rel_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Result register: captured on the edge that enters DONE so h/e/l
  // change together with the done pulse, then held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hel_reg <= 3'b000;
    end else if (load_result) begin
      hel_reg <= rel_to_hel(rel_next);
    end
  end

  assign h       = hel_reg[2];
  assign e       = hel_reg[1];
  assign l       = hel_reg[0];
  assign bit_cnt = cnt_reg;

endmodule

// File: tb/tb_serial_comparator.sv
// Self-checking bench for serial_comparator (WIDTH=8): a table of
// directed comparisons, an asynchronous-reset abort, and randomized
// operands checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_comparator;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic             h;
  logic             e;
  logic             l;
  logic [CNT_W-1:0] bit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_comparator #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .h        (h),
    .e        (e),
    .l        (l),
    .bit_cnt  (bit_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: beats consumed. Full build always WIDTH; early build stops
  // at the most significant differing bit, counted from the MSB.
  function automatic int model_cnt(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    int diff;
    diff = int'(av ^ bv);
    if (!EARLY || diff == 0) return WIDTH;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (diff >= (1 << k)) return WIDTH - k;
    end
    return WIDTH;
  endfunction

  // One comparison, entered and left at #1 after an edge with the DUT in
  // IDLE. gaps[i] inserts 3 idle cycles (with junk on a/b) after beat i+1.
  task automatic do_cmp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [WIDTH-1:0] gaps, input bit poke_shift,
                        input bit poke_done, input bit eh, input bit ee,
                        input bit el, input int ecnt);
    chk("idle_busy", int'(busy), 0);
    chk("idle_ready", int'(in_ready), 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ready_rise", int'(in_ready), 1);
    for (int i = 0; i < ecnt; i++) begin
      a        = av[WIDTH-1-i];
      b        = bv[WIDTH-1-i];
      in_valid = 1'b1;
      if (poke_shift && i == 1) start = 1'b1;
      chk("beat_ready", int'(in_ready), 1);
      chk("beat_nodone", int'(done), 0);
      chk("beat_cnt", int'(bit_cnt), i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      start    = 1'b0;
      if (gaps[i] && (i + 1 < ecnt)) begin
        repeat (3) begin
          a = 1'($urandom);
          b = 1'($urandom);
          chk("gap_cnt", int'(bit_cnt), i + 1);
          chk("gap_busy", int'(busy), 1);
          @(posedge clk); #1;
        end
      end
    end
    chk("done_pulse", int'(done), 1);
    chk("done_ready", int'(in_ready), 0);
    chk("res_h", int'(h), int'(eh));
    chk("res_e", int'(e), int'(ee));
    chk("res_l", int'(l), int'(el));
    chk("res_cnt", int'(bit_cnt), ecnt);
    if (poke_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_drop", int'(done), 0);
    chk("back_idle", int'(busy), 0);
    chk("hold_h", int'(h), int'(eh));
    chk("hold_e", int'(e), int'(ee));
    chk("hold_l", int'(l), int'(el));
    chk("hold_cnt", int'(bit_cnt), ecnt);
    if (poke_done) begin
      @(posedge clk); #1;
      chk("no_queue_busy", int'(busy), 0);
      chk("no_queue_ready", int'(in_ready), 0);
      chk("hold2_e", int'(e), int'(ee));
    end
    $display("cmp a=%02h b=%02h -> h=%0b e=%0b l=%0b bit_cnt=%0d",
             av, bv, h, e, l, bit_cnt);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ready"}, int'(in_ready), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_h"}, int'(h), 0);
    chk({tag, "_e"}, int'(e), 0);
    chk({tag, "_l"}, int'(l), 0);
    chk({tag, "_cnt"}, int'(bit_cnt), 0);
  endtask

  typedef struct {
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] bv;
    logic [WIDTH-1:0] gaps;
    bit               ps;
    bit               pd;
    bit               eh;
    bit               ee;
    bit               el;
    int               ecnt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'hA5, 8'h5A, 8'h00,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, EARLY ? 1 : 8};
    vecs[1] = '{8'h3C, 8'h3C, 8'h00,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8};
    vecs[2] = '{8'h10, 8'h11, 8'b0001_0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8};
    vecs[3] = '{8'hC3, 8'hC7, 8'h00,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, EARLY ? 6 : 8};
    vecs[4] = '{8'h80, 8'h7F, 8'h00,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, EARLY ? 1 : 8};

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    a        = 1'b0;
    b        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("post_reset");

    // Directed table; entries run back to back (start on first IDLE cycle).
    for (int i = 0; i < 5; i++) begin
      do_cmp(vecs[i].av, vecs[i].bv, vecs[i].gaps, vecs[i].ps, vecs[i].pd,
             vecs[i].eh, vecs[i].ee, vecs[i].el, vecs[i].ecnt);
    end

    // Asynchronous reset after beat 4 of FF vs 00 discards the run.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a        = 1'b1;
      b        = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    chk_all_zero("rst_held");
    #2 rst = 1'b0;
    @(posedge clk); #1;
    do_cmp(8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8);

    // Randomized operands against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] av;
      logic [WIDTH-1:0] bv;
      logic [WIDTH-1:0] gv;
      int               sel;
      av  = WIDTH'($urandom);
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      bv = av;
      else if (sel == 1) bv = av ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
      else               bv = WIDTH'($urandom);
      gv = WIDTH'($urandom) & WIDTH'($urandom) & WIDTH'($urandom);
      do_cmp(av, bv, gv, 1'($urandom), 1'($urandom),
             av > bv, av == bv, av < bv, model_cnt(av, bv));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
